// File: rtl/sort_bank_if.sv
// sort_bank_if: row-load handshake, sort status and registered read port of sort_bank
interface sort_bank_if #(
  parameter int ROWS        = 16,
  parameter int ENTRIES     = 35,
  parameter int IDX_W       = 14,
  parameter int OUT_ENTRIES = 27
);
  logic                           abort;
  logic                           descend;
  logic                           in_valid;
  logic                           in_ready;
  logic [ENTRIES*IDX_W-1:0]       in_row;
  logic                           busy;
  logic                           done;
  logic [$clog2(ROWS)-1:0]        rd_row;
  logic                           rd_valid;
  logic [OUT_ENTRIES*IDX_W-1:0]   rd_data;
  modport master (
    output abort, descend, in_valid, in_row, rd_row,
    input  in_ready, busy, done, rd_valid, rd_data
  );
  modport slave (
    input  abort, descend, in_valid, in_row, rd_row,
    output in_ready, busy, done, rd_valid, rd_data
  );
endinterface

// File: rtl/sort_bank.sv
// sort_bank: loads ROWS rows, sorts each in place with one shared odd-even transposition
// sorter, then serves the top OUT_ENTRIES sorted entries of a selected row.
module sort_bank #(
  parameter int ROWS        = 16,
  parameter int ENTRIES     = 35,
  parameter int IDX_W       = 14,
  parameter int OUT_ENTRIES = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  sort_bank_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(ENTRIES + 2);
  localparam int RB = ENTRIES * IDX_W;
  localparam int OB = OUT_ENTRIES * IDX_W;
  typedef enum logic [1:0] {LOAD, SORT, READY} state_t;
  state_t           state_q, state_d;
  logic [RB-1:0]    mem_q [ROWS];
  logic [RB-1:0]    mem_d [ROWS];
  logic [IDX_W-1:0] work_q [ENTRIES];
  logic [IDX_W-1:0] work_d [ENTRIES];
  logic [RW-1:0]    wr_ptr_q, wr_ptr_d, sort_row_q, sort_row_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic             desc_q, desc_d, done_q, done_d, rd_valid_q, rd_valid_d;
  logic [OB-1:0]    rd_data_q, rd_data_d;
  logic             accept;
  assign bus.in_ready = state_q != SORT;
  assign bus.busy     = state_q == SORT;
  assign bus.done     = done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign accept       = bus.in_valid && bus.in_ready;
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    work_d     = work_q;
    wr_ptr_d   = wr_ptr_q;
    sort_row_d = sort_row_q;
    pass_d     = pass_q;
    desc_d     = desc_q;
    done_d     = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_data_d  = int'(bus.rd_row) < ROWS ? mem_q[bus.rd_row][RB-1 -: OB] : '0;
    if (bus.abort) begin
      state_d    = LOAD;
      wr_ptr_d   = '0;
      sort_row_d = '0;
      pass_d     = '0;
      rd_valid_d = 1'b0;
    end else if (accept) begin
      // wr_ptr is already zero in READY, so a new block starts at row 0
      mem_d[wr_ptr_q] = bus.in_row;
      rd_valid_d      = 1'b0;
      state_d         = wr_ptr_q == RW'(ROWS - 1) ? SORT : LOAD;
      wr_ptr_d        = wr_ptr_q == RW'(ROWS - 1) ? '0 : wr_ptr_q + 1'b1;
      desc_d          = wr_ptr_q == RW'(ROWS - 1) ? bus.descend : desc_q;
    end else if (state_q == SORT) begin
      pass_d = pass_q == PW'(ENTRIES + 1) ? '0 : pass_q + 1'b1;
      if (pass_q == '0) begin
        for (int k = 0; k < ENTRIES; k++) work_d[k] = mem_q[sort_row_q][k*IDX_W +: IDX_W];
      end else if (pass_q == PW'(ENTRIES + 1)) begin
        for (int k = 0; k < ENTRIES; k++) mem_d[sort_row_q][k*IDX_W +: IDX_W] = work_q[k];
        sort_row_d = sort_row_q == RW'(ROWS - 1) ? '0 : sort_row_q + 1'b1;
        if (sort_row_q == RW'(ROWS - 1)) begin
          state_d    = READY;
          done_d     = 1'b1;
          rd_valid_d = 1'b1;
        end
      end else begin
        // pass index pass_q-1: even passes start at pair (0,1), odd at (1,2)
        for (int i = 0; i < ENTRIES - 1; i++)
          if (1'(i) == ~pass_q[0] &&
              (desc_q ? work_q[i] < work_q[i+1] : work_q[i] > work_q[i+1])) begin
            work_d[i]   = work_q[i+1];
            work_d[i+1] = work_q[i];
          end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      wr_ptr_q   <= '0;
      sort_row_q <= '0;
      pass_q     <= '0;
      desc_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      sort_row_q <= sort_row_d;
      pass_q     <= pass_d;
      desc_q     <= desc_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end
  always_ff @(posedge clk) begin
    mem_q  <= mem_d;
    work_q <= work_d;
  end
endmodule

// File: tb/tb_sort_bank.sv
// tb_sort_bank: directed checks of the default sort_bank plus two small configurations
module tb_sort_bank;
  localparam int RB = 35 * 14;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat;
  always #5 clk = ~clk;

  sort_bank_if #(.ROWS(16), .ENTRIES(35), .IDX_W(14), .OUT_ENTRIES(27)) m ();
  sort_bank_if #(.ROWS(2),  .ENTRIES(2),  .IDX_W(4),  .OUT_ENTRIES(1))  s ();
  sort_bank_if #(.ROWS(3),  .ENTRIES(2),  .IDX_W(4),  .OUT_ENTRIES(2))  t ();
  sort_bank #(.ROWS(16), .ENTRIES(35), .IDX_W(14), .OUT_ENTRIES(27)) dut   (.clk(clk), .rst_n(rst_n), .bus(m));
  sort_bank #(.ROWS(2),  .ENTRIES(2),  .IDX_W(4),  .OUT_ENTRIES(1))  dut_s (.clk(clk), .rst_n(rst_n), .bus(s));
  sort_bank #(.ROWS(3),  .ENTRIES(2),  .IDX_W(4),  .OUT_ENTRIES(2))  dut_t (.clk(clk), .rst_n(rst_n), .bus(t));

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RB-1:0] mk(input int r);
    logic [RB-1:0] v;
    for (int k = 0; k < 35; k++) v[k*14 +: 14] = 14'((34 - k) * 3 + r);
    return v;
  endfunction

  function automatic logic [RB-1:0] fill(input logic [13:0] x);
    logic [RB-1:0] v;
    for (int k = 0; k < 35; k++) v[k*14 +: 14] = x;
    return v;
  endfunction

  function automatic logic [27*14-1:0] exp_rows(input int r, input bit desc);
    logic [27*14-1:0] v;
    for (int j = 0; j < 27; j++) v[j*14 +: 14] = desc ? 14'((26 - j) * 3 + r) : 14'((8 + j) * 3 + r);
    return v;
  endfunction

  task automatic push(input logic [RB-1:0] r);
    check("m_in_ready", m.in_ready, 1);
    m.in_row = r;
    m.in_valid = 1'b1;
    @(posedge clk); #1;
    m.in_valid = 1'b0;
  endtask

  task automatic push_s(input logic [7:0] r);
    s.in_row = r; s.in_valid = 1'b1;
    @(posedge clk); #1;
    s.in_valid = 1'b0;
  endtask

  task automatic push_t(input logic [7:0] r);
    t.in_row = r; t.in_valid = 1'b1;
    @(posedge clk); #1;
    t.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int which, output int n);
    n = 0;
    while (!(which == 0 ? m.done : which == 1 ? s.done : t.done) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic rd(input int r);
    m.rd_row = 4'(r);
    @(posedge clk); #1;
  endtask

  initial begin
    {m.abort, m.descend, m.in_valid, m.in_row, m.rd_row} = '0;
    {s.abort, s.descend, s.in_valid, s.in_row, s.rd_row} = '0;
    {t.abort, t.descend, t.in_valid, t.in_row, t.rd_row} = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", m.in_ready, 1);
    check("rst_busy", m.busy, 0);
    check("rst_done", m.done, 0);
    check("rst_rd_valid", m.rd_valid, 0);
    check("rst_rd_data", m.rd_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ascending sort of reversed rows
    for (int r = 0; r < 16; r++) push(mk(r));
    check("t1_busy", m.busy, 1);
    check("t1_in_ready", m.in_ready, 0);
    wait_done(0, lat);
    check("t1_latency", lat, 592);
    check("t1_rd_valid", m.rd_valid, 1);
    check("t1_in_ready_ready", m.in_ready, 1);
    rd(5);
    check("t1_done_pulse", m.done, 0);
    check("t1_row5", m.rd_data, exp_rows(5, 0));
    rd(15);
    check("t1_row15", m.rd_data, exp_rows(15, 0));

    // descending, with a 3-cycle in_valid gap mid-load; first push leaves READY
    m.descend = 1'b1;
    push(mk(0));
    check("t2_rd_valid_fall", m.rd_valid, 0);
    for (int r = 1; r < 16; r++) begin
      if (r == 8) begin repeat (3) @(posedge clk); #1; end
      push(mk(r));
    end
    m.descend = 1'b0;
    wait_done(0, lat);
    check("t2_latency", lat, 592);
    rd(0);
    check("t2_row0", m.rd_data, exp_rows(0, 1));
    for (int r = 0; r < 16; r++) begin
      rd(r);
      check($sformatf("t2_row%0d_slot0", r), m.rd_data[13:0], 14'(78 + r));
    end

    // max key among equal keys, and an all-equal row
    begin
      logic [RB-1:0] r0;
      logic [27*14-1:0] e0;
      r0 = fill(14'h1555);
      r0[13:0] = 14'h3FFF;
      push(r0);
      push(fill(14'h1555));
      for (int r = 2; r < 16; r++) push(mk(r));
      wait_done(0, lat);
      check("t3_latency", lat, 592);
      e0 = fill(14'h1555)[27*14-1:0];
      e0[26*14 +: 14] = 14'h3FFF;
      rd(0);
      check("t3_row0", m.rd_data, e0);
      rd(1);
      check("t3_row1_equal", m.rd_data, fill(14'h1555)[27*14-1:0]);
    end

    // abort 100 cycles into SORT, then a full reload
    for (int r = 0; r < 16; r++) push(mk(r));
    repeat (100) @(posedge clk);
    #1;
    m.abort = 1'b1;
    @(posedge clk); #1;
    m.abort = 1'b0;
    check("t4_busy", m.busy, 0);
    check("t4_in_ready", m.in_ready, 1);
    check("t4_done", m.done, 0);
    check("t4_rd_valid", m.rd_valid, 0);
    @(posedge clk); #1;
    check("t4_done_later", m.done, 0);
    m.descend = 1'b1;
    for (int r = 0; r < 16; r++) push(mk(r));
    m.descend = 1'b0;
    wait_done(0, lat);
    check("t4_latency", lat, 592);
    rd(5);
    check("t4_row5", m.rd_data, exp_rows(5, 1));

    // row accepted in READY lands in row 0; 15 more rows complete the block
    begin
      logic [RB-1:0] ramp;
      logic [27*14-1:0] er;
      for (int k = 0; k < 35; k++) ramp[k*14 +: 14] = 14'(k);
      for (int j = 0; j < 27; j++) er[j*14 +: 14] = 14'(8 + j);
      push(ramp);
      check("t5_rd_valid", m.rd_valid, 0);
      check("t5_busy", m.busy, 0);
      for (int r = 1; r < 16; r++) push(mk(r));
      check("t5_busy_after_16", m.busy, 1);
      wait_done(0, lat);
      check("t5_latency", lat, 592);
      rd(0);
      check("t5_row0", m.rd_data, er);
      rd(15);
      check("t5_row15", m.rd_data, exp_rows(15, 0));
    end

    // out-of-range row select on a 3-row bank
    push_t(8'h11);
    push_t(8'h22);
    push_t(8'h5A);
    wait_done(2, lat);
    check("t5_t_latency", lat, 12);
    t.rd_row = 2'd2;
    @(posedge clk); #1;
    check("t5_t_row2", t.rd_data, 8'hA5);
    t.rd_row = 2'd3;
    @(posedge clk); #1;
    check("t5_t_row3_zero", t.rd_data, 8'h00);

    // minimal configuration, both orders
    push_s(8'h39);
    push_s(8'hF1);
    wait_done(1, lat);
    check("t6_asc_latency", lat, 8);
    s.rd_row = 1'b0;
    @(posedge clk); #1;
    check("t6_asc_row0", s.rd_data, 4'h9);
    s.rd_row = 1'b1;
    @(posedge clk); #1;
    check("t6_asc_row1", s.rd_data, 4'hF);
    s.descend = 1'b1;
    push_s(8'h39);
    push_s(8'hF1);
    s.descend = 1'b0;
    wait_done(1, lat);
    check("t6_desc_latency", lat, 8);
    s.rd_row = 1'b0;
    @(posedge clk); #1;
    check("t6_desc_row0", s.rd_data, 4'h3);
    s.rd_row = 1'b1;
    @(posedge clk); #1;
    check("t6_desc_row1", s.rd_data, 4'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
